// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory that answers MEM-stage load/store
// requests one at a time, stalling the pipeline while a request is in flight.
// Optional feature macro: DMEM_BYTE_WRITE_EN adds the be port for per-lane stores.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rd,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    localparam int IDXW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [31:0]       wd_q, wd_d;
    logic [3:0]        be_q, be_d;
    logic              fault_q, fault_d;
    logic [31:0]       rd_q;

    logic              req;
    logic [IDXW-1:0]   addrIdx;
    logic              addrFault;
    logic [3:0]        laneEn;
    logic              loadNow;

    logic [31:0]       mem [DEPTH];

    assign req       = MemRead | MemWrite;
    assign addrIdx   = addr[IDXW+1:2];
    // Misaligned addresses and any set bit above the word index are faults.
    assign addrFault = (addr[1:0] != 2'b00) || (addr[31:IDXW+2] != '0);

`ifdef DMEM_BYTE_WRITE_EN
    assign laneEn = be;
`else
    assign laneEn = 4'hF;
`endif

    // Next-state logic: latch the request in IDLE, count down in WAIT, answer in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        be_d    = be_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    write_d = MemWrite;
                    idx_d   = addrIdx;
                    wd_d    = wd;
                    be_d    = laneEn;
                    fault_d = addrFault;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A load samples the array on the edge that enters RESP, so rd is valid during RESP.
    assign loadNow = (state_d == S_RESP) && (state_q != S_RESP) && !write_d;

    // Control registers and the load data register; reset abandons any pending request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wd_q    <= 32'd0;
            be_q    <= 4'd0;
            fault_q <= 1'b0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            fault_q <= fault_d;
            if (loadNow) begin
                rd_q <= fault_d ? 32'd0 : mem[idx_d];
            end
        end
    end

    // Stores commit on the edge that ends RESP; faulted stores never touch the array.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && write_q && !fault_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
                end
            end
        end
    end

    assign rd    = rd_q;
    assign ready = (state_q == S_RESP);
    assign err   = (state_q == S_RESP) && fault_q;
    assign stall = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);

endmodule
